// File: rtl/systolic_seq.sv
// -----------------------------------------------------------------------------
// systolic_seq
//   Sequencer for a linear chain of DEPTH multiply-accumulate PEs that
//   computes a signed dot product. Operands are loaded through a valid/ready
//   command port. START feeds element pair k into PE k during feed cycle k,
//   so the partial sum ripples down the c chain in step with the operands.
//   The sum leaving the last PE is returned on a valid/ready response port.
//
// Optional feature (macro SYSTOLIC_SEQ_ACCUM_EN):
//   defined   - pe_c0 is driven from an accumulator that takes rsp_data on
//               every response handshake, so consecutive STARTs accumulate.
//   undefined - no accumulator; pe_c0 is tied to zero.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   cmd_valid/cmd_ready   command handshake
//   cmd_op                0 LOAD_A, 1 LOAD_B, 2 START, 3 CLEAR
//   cmd_idx, cmd_data     element index / operand for LOAD_A and LOAD_B
//   rsp_valid/rsp_ready   response handshake
//   rsp_data              dot-product result (CW bits, wraps modulo 2^CW)
//   busy                  sequencer is not idle
//   pe_a, pe_b            per-PE operands, PE k at bits [k*DW +: DW]
//   pe_c0                 c_in of PE 0
//   pe_c_last             c_out of PE DEPTH-1
//   pe_rst                active-high PE reset (system reset or CLEAR pulse)
// -----------------------------------------------------------------------------
module systolic_seq #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned DW    = 16,
    parameter int unsigned CW    = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [1:0]            cmd_op,
    input  logic [3:0]            cmd_idx,
    input  logic [DW-1:0]         cmd_data,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [CW-1:0]         rsp_data,
    output logic                  busy,
    output logic [DEPTH*DW-1:0]   pe_a,
    output logic [DEPTH*DW-1:0]   pe_b,
    output logic [CW-1:0]         pe_c0,
    input  logic [CW-1:0]         pe_c_last,
    output logic                  pe_rst
);

    // Feed counter shares the index width so it can address up to 16 PEs.
    localparam int unsigned TW = 4;

    localparam logic [1:0] OP_LOAD_A = 2'd0;
    localparam logic [1:0] OP_LOAD_B = 2'd1;
    localparam logic [1:0] OP_START  = 2'd2;
    localparam logic [1:0] OP_CLEAR  = 2'd3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FEED  = 2'd1,
        DRAIN = 2'd2,
        RESP  = 2'd3
    } state_e;

    state_e                       state_q, state_d;
    logic [TW-1:0]                t_q, t_d;
    logic [DEPTH-1:0][DW-1:0]     a_q, a_d;
    logic [DEPTH-1:0][DW-1:0]     b_q, b_d;
    logic                         clr_q, clr_d;
    logic                         rsp_valid_q, rsp_valid_d;
    logic [CW-1:0]                rsp_data_q, rsp_data_d;
    logic                         cmd_ready_q, cmd_ready_d;
    logic                         busy_q, busy_d;
    logic [DEPTH-1:0][DW-1:0]     pe_a_q, pe_a_d;
    logic [DEPTH-1:0][DW-1:0]     pe_b_q, pe_b_d;
    logic                         cmd_fire_c;

`ifdef SYSTOLIC_SEQ_ACCUM_EN
    logic [CW-1:0]                acc_q, acc_d;
`endif

    assign cmd_fire_c = cmd_valid && cmd_ready_q;

    // Next-state, storage updates and next values of the registered outputs.
    always_comb begin
        state_d     = state_q;
        t_d         = t_q;
        a_d         = a_q;
        b_d         = b_q;
        clr_d       = 1'b0;
        rsp_valid_d = rsp_valid_q;
        rsp_data_d  = rsp_data_q;
`ifdef SYSTOLIC_SEQ_ACCUM_EN
        acc_d       = acc_q;
`endif

        case (state_q)
            IDLE: begin
                if (cmd_fire_c) begin
                    case (cmd_op)
                        OP_LOAD_A: begin
                            // Indices at or beyond DEPTH match no slot and are dropped.
                            for (int k = 0; k < int'(DEPTH); k++) begin
                                if (cmd_idx == TW'(k)) begin
                                    a_d[k] = cmd_data;
                                end
                            end
                        end
                        OP_LOAD_B: begin
                            for (int k = 0; k < int'(DEPTH); k++) begin
                                if (cmd_idx == TW'(k)) begin
                                    b_d[k] = cmd_data;
                                end
                            end
                        end
                        OP_START: begin
                            state_d = FEED;
                            t_d     = '0;
                        end
                        OP_CLEAR: begin
                            a_d   = '0;
                            b_d   = '0;
                            clr_d = 1'b1;
`ifdef SYSTOLIC_SEQ_ACCUM_EN
                            acc_d = '0;
`endif
                        end
                        default: ;
                    endcase
                end
            end
            FEED: begin
                if (t_q == TW'(DEPTH - 1)) begin
                    state_d = DRAIN;
                end else begin
                    t_d = t_q + TW'(1);
                end
            end
            DRAIN: begin
                // Last PE registered the full sum on the previous edge.
                state_d     = RESP;
                rsp_valid_d = 1'b1;
                rsp_data_d  = pe_c_last;
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d     = IDLE;
                    rsp_valid_d = 1'b0;
`ifdef SYSTOLIC_SEQ_ACCUM_EN
                    acc_d       = rsp_data_q;
`endif
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Outputs are registered, so they are decoded from the next state.
        cmd_ready_d = (state_d == IDLE);
        busy_d      = (state_d != IDLE);
        pe_a_d      = '0;
        pe_b_d      = '0;
        if (state_d == FEED) begin
            for (int k = 0; k < int'(DEPTH); k++) begin
                if (t_d == TW'(k)) begin
                    pe_a_d[k] = a_q[k];
                    pe_b_d[k] = b_q[k];
                end
            end
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            t_q         <= '0;
            a_q         <= '0;
            b_q         <= '0;
            clr_q       <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            cmd_ready_q <= 1'b1;
            busy_q      <= 1'b0;
            pe_a_q      <= '0;
            pe_b_q      <= '0;
        end else begin
            state_q     <= state_d;
            t_q         <= t_d;
            a_q         <= a_d;
            b_q         <= b_d;
            clr_q       <= clr_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            cmd_ready_q <= cmd_ready_d;
            busy_q      <= busy_d;
            pe_a_q      <= pe_a_d;
            pe_b_q      <= pe_b_d;
        end
    end

`ifdef SYSTOLIC_SEQ_ACCUM_EN
    // Running accumulator seeding the head of the chain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    assign pe_c0 = acc_q;
`else
    assign pe_c0 = '0;
`endif

    assign cmd_ready = cmd_ready_q;
    assign busy      = busy_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign pe_a      = pe_a_q;
    assign pe_b      = pe_b_q;

    // PEs are held in reset with the system and for one cycle after CLEAR.
    assign pe_rst    = ~rst_n | clr_q;

endmodule

// File: tb/tb_systolic_seq.sv
// -----------------------------------------------------------------------------
// tb_systolic_seq
//   Directed bench for systolic_seq with a behavioural PE chain attached.
//   Expected results are hand-computed dot products.
// -----------------------------------------------------------------------------
module tb_systolic_seq;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned DW    = 16;
    localparam int unsigned CW    = 32;

    localparam logic [1:0] OP_LOAD_A = 2'd0;
    localparam logic [1:0] OP_LOAD_B = 2'd1;
    localparam logic [1:0] OP_START  = 2'd2;
    localparam logic [1:0] OP_CLEAR  = 2'd3;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 cmd_valid = 1'b0;
    logic                 cmd_ready;
    logic [1:0]           cmd_op = '0;
    logic [3:0]           cmd_idx = '0;
    logic [DW-1:0]        cmd_data = '0;
    logic                 rsp_valid;
    logic                 rsp_ready = 1'b0;
    logic [CW-1:0]        rsp_data;
    logic                 busy;
    logic [DEPTH*DW-1:0]  pe_a;
    logic [DEPTH*DW-1:0]  pe_b;
    logic [CW-1:0]        pe_c0;
    logic [CW-1:0]        pe_c_last;
    logic                 pe_rst;

    int pass_cnt = 0;
    int total    = 0;

    logic [DW-1:0] va [DEPTH];
    logic [DW-1:0] vb [DEPTH];

    systolic_seq #(.DEPTH(DEPTH), .DW(DW), .CW(CW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_idx   (cmd_idx),
        .cmd_data  (cmd_data),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .busy      (busy),
        .pe_a      (pe_a),
        .pe_b      (pe_b),
        .pe_c0     (pe_c0),
        .pe_c_last (pe_c_last),
        .pe_rst    (pe_rst)
    );

    always #5 clk = ~clk;

    // Behavioural PE chain: c_out <= c_in + a*b, signed, wrapping at CW bits.
    function automatic logic [CW-1:0] mul(input logic signed [DW-1:0] a,
                                          input logic signed [DW-1:0] b);
        logic signed [CW-1:0] ae;
        logic signed [CW-1:0] be;
        ae = CW'(a);
        be = CW'(b);
        return ae * be;
    endfunction

    logic [CW-1:0] pc [DEPTH];

    always_ff @(posedge clk or posedge pe_rst) begin
        if (pe_rst) begin
            for (int k = 0; k < int'(DEPTH); k++) pc[k] <= '0;
        end else begin
            pc[0] <= pe_c0 + mul(pe_a[0 +: DW], pe_b[0 +: DW]);
            for (int k = 1; k < int'(DEPTH); k++)
                pc[k] <= pc[k-1] + mul(pe_a[k*DW +: DW], pe_b[k*DW +: DW]);
        end
    end

    assign pe_c_last = pc[DEPTH-1];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // Present one command and hold it until the accepting edge has passed.
    task automatic send(input logic [1:0] op, input logic [3:0] idx, input logic [DW-1:0] data);
        int n;
        n = 0;
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_idx   = idx;
        cmd_data  = data;
        while (!cmd_ready && n < 30) begin
            tick();
            n++;
        end
        chk("cmd_ready_wait", 64'(cmd_ready), 64'd1);
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic load_vec();
        for (int k = 0; k < int'(DEPTH); k++) begin
            send(OP_LOAD_A, 4'(k), va[k]);
            send(OP_LOAD_B, 4'(k), vb[k]);
        end
    endtask

    // START, wait for the response, check latency and value, then consume it.
    task automatic run_dot(input string tag, input logic [CW-1:0] exp, input logic early_ready);
        int lat;
        lat = 0;
        rsp_ready = early_ready;
        send(OP_START, 4'd0, '0);
        while (!rsp_valid && lat < 20) begin
            tick();
            lat++;
        end
        chk({tag, "_lat"}, 64'(lat), 64'd5);
        chk(tag, 64'(rsp_data), 64'(exp));
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        chk({tag, "_idle"}, {62'd0, busy, cmd_ready}, 64'b01);
    endtask

    initial begin
        logic [DEPTH*DW-1:0] ea;
        logic [DEPTH*DW-1:0] eb;
        logic                seen;

        // ---- reset values ----
        tick();
        tick();
        chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("rst_rsp_data",  64'(rsp_data),  64'd0);
        chk("rst_busy",      64'(busy),      64'd0);
        chk("rst_pe_a",      64'(pe_a),      64'd0);
        chk("rst_pe_b",      64'(pe_b),      64'd0);
        chk("rst_pe_c0",     64'(pe_c0),     64'd0);
        chk("rst_pe_rst",    64'(pe_rst),    64'd1);
        rst_n = 1'b1;
        tick();
        chk("rel_cmd_ready", 64'(cmd_ready), 64'd1);
        chk("rel_pe_rst",    64'(pe_rst),    64'd0);

        // ---- CLEAR pulses pe_rst for one cycle ----
        send(OP_CLEAR, 4'd0, '0);
        chk("clr_pulse_hi", 64'(pe_rst), 64'd1);
        tick();
        chk("clr_pulse_lo", 64'(pe_rst), 64'd0);

        // ---- basic dot product with feed-pattern and latency checks ----
        va = '{16'd1, 16'd2, 16'd3, 16'd4};
        vb = '{16'd5, 16'd6, 16'd7, 16'd8};
        load_vec();
        send(OP_LOAD_A, 4'd4,  16'h0064);
        send(OP_LOAD_B, 4'd15, 16'h0064);
        send(OP_START, 4'd0, '0);
        for (int k = 0; k < int'(DEPTH); k++) begin
            ea = '0;
            eb = '0;
            ea[k*DW +: DW] = va[k];
            eb[k*DW +: DW] = vb[k];
            chk("feed_pe_a", 64'(pe_a), 64'(ea));
            chk("feed_pe_b", 64'(pe_b), 64'(eb));
            chk("feed_cmd_ready", 64'(cmd_ready), 64'd0);
            tick();
        end
        chk("drain_pe_a",      64'(pe_a),      64'd0);
        chk("drain_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("drain_busy",      64'(busy),      64'd1);
        tick();
        chk("basic_valid_e5", 64'(rsp_valid), 64'd1);
        chk("basic_data",     64'(rsp_data),  64'd70);

        // ---- backpressure: response held for 6 cycles ----
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("bp_valid",     64'(rsp_valid), 64'd1);
            chk("bp_data",      64'(rsp_data),  64'd70);
            chk("bp_cmd_ready", 64'(cmd_ready), 64'd0);
            chk("bp_busy",      64'(busy),      64'd1);
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        chk("bp_release_valid", 64'(rsp_valid), 64'd0);
        chk("bp_release_busy",  64'(busy),      64'd0);
        chk("bp_release_ready", 64'(cmd_ready), 64'd1);

        // ---- signed operands ----
        send(OP_CLEAR, 4'd0, '0);
        va = '{16'hFFFD, 16'd2, 16'hFFFF, 16'd7};
        vb = '{16'd4, 16'hFFFB, 16'd6, 16'd2};
        load_vec();
        run_dot("signed", 32'hFFFF_FFF2, 1'b0);

        // ---- wrap-around, rsp_ready already high before the response ----
        send(OP_CLEAR, 4'd0, '0);
        va = '{16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF};
        vb = '{16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF};
        load_vec();
        run_dot("wrap", 32'hFFFC_0004, 1'b1);

        // ---- reset mid-FEED ----
        send(OP_CLEAR, 4'd0, '0);
        va = '{16'd1, 16'd2, 16'd3, 16'd4};
        vb = '{16'd5, 16'd6, 16'd7, 16'd8};
        load_vec();
        send(OP_START, 4'd0, '0);
        tick();
        tick();
        chk("mid_feed_busy", 64'(busy), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("arst_busy",      64'(busy),      64'd0);
        chk("arst_pe_a",      64'(pe_a),      64'd0);
        chk("arst_pe_b",      64'(pe_b),      64'd0);
        chk("arst_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("arst_pe_rst",    64'(pe_rst),    64'd1);
        chk("arst_cmd_ready", 64'(cmd_ready), 64'd1);
        tick();
        rst_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            seen = seen | rsp_valid;
        end
        chk("arst_no_rsp", 64'(seen), 64'd0);
        run_dot("arst_zero", 32'd0, 1'b0);

        // ---- CLEAR immediately followed by START ----
        va = '{16'd9, 16'd9, 16'd9, 16'd9};
        vb = '{16'd9, 16'd9, 16'd9, 16'd9};
        load_vec();
        send(OP_CLEAR, 4'd0, '0);
        run_dot("clr_start", 32'd0, 1'b0);

`ifdef SYSTOLIC_SEQ_ACCUM_EN
        // ---- accumulation across STARTs ----
        send(OP_CLEAR, 4'd0, '0);
        va = '{16'd1, 16'd2, 16'd3, 16'd4};
        vb = '{16'd5, 16'd6, 16'd7, 16'd8};
        load_vec();
        run_dot("acc_first", 32'd70, 1'b0);
        chk("acc_pe_c0", 64'(pe_c0), 64'd70);
        run_dot("acc_second", 32'd140, 1'b0);
        send(OP_CLEAR, 4'd0, '0);
        chk("acc_clr_pulse", 64'(pe_rst), 64'd1);
        chk("acc_clr_c0",    64'(pe_c0),  64'd0);
        run_dot("acc_cleared", 32'd0, 1'b0);
`endif

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule
